// File: rtl/and_shift_mul.sv
// Sequential unsigned multiplier: each cycle ANDs A with BPC bits of B and adds the shifted partial products.
// Latency: WIDTH/BPC RUN cycles after accept (fewer with EARLY_EXIT), then at least one DONE cycle.
// Backpressure: result and out_valid_o hold in DONE until out_ready_i; in_ready_o is high only in IDLE.
module and_shift_mul #(
    parameter int WIDTH      = 32,
    parameter int BPC        = 1,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   Y_o,
    output logic                 busy_o
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     b_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   pp_sum;
    logic [2*WIDTH-1:0]   y_reg;
    logic [CW-1:0]        cnt;
    logic                 last;

    // Sum of the BPC gated partial products retired this cycle, aligned to their bit weight.
    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BPC; k++) begin
            if (b_reg[k]) begin
                pp_sum = pp_sum + ({{WIDTH{1'b0}}, a_reg} << (int'(cnt) * BPC + k));
            end
        end
    end

    assign acc_next = acc + pp_sum;
    assign b_next   = b_reg >> BPC;
    assign last     = (cnt == CW'(N - 1)) || (EARLY_EXIT && (b_next == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            y_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_reg <= A_i;
                        b_reg <= B_i;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // Y_o has its own register so it survives the acc clear on the next accept.
                        y_reg <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign out_valid_o = (state == DONE);
    assign Y_o         = y_reg;

endmodule
